// File: rtl/sampling_decimator_if.sv
// rtl/sampling_decimator_if.sv - sample stream in / block average out bundle for sampling_decimator
//
// Purpose: groups the acquisition-side strobe/sample signals and the
// logger-side average/strobe signals of the boxcar decimator.
//
// Signals:
//   data_i    signed input sample                     (master -> slave)
//   valid_i   data_i is a sample this cycle           (master -> slave)
//   clear_i   abort the partial block                 (master -> slave)
//   log2_n_i  requested k, block length 2^k           (master -> slave)
//   data_o    rounded block average, held             (slave -> master)
//   valid_o   one-cycle strobe for a new data_o       (slave -> master)
//   busy_o    partial block in progress               (slave -> master)
//
// Modports: master = sample source / result sink, slave = decimator.

interface sampling_decimator_if #(
    parameter int WIDTH    = 16,
    parameter int MAX_LOG2 = 10
);
    localparam int KW = $clog2(MAX_LOG2 + 1);

    logic signed [WIDTH-1:0] data_i;
    logic                    valid_i;
    logic                    clear_i;
    logic [KW-1:0]           log2_n_i;
    logic signed [WIDTH-1:0] data_o;
    logic                    valid_o;
    logic                    busy_o;

    modport master (
        output data_i,
        output valid_i,
        output clear_i,
        output log2_n_i,
        input  data_o,
        input  valid_o,
        input  busy_o
    );

    modport slave (
        input  data_i,
        input  valid_i,
        input  clear_i,
        input  log2_n_i,
        output data_o,
        output valid_o,
        output busy_o
    );
endinterface

// File: rtl/sampling_decimator.sv
// rtl/sampling_decimator.sv - boxcar decimator emitting rounded averages of 2^k-sample blocks
//
// Purpose: sums blocks of 2^k consecutive valid samples and emits one
// rounded (half toward +inf) block average per block. k is sampled from
// log2_n_i only at a block start and clamped to MAX_LOG2.
//
// Ports:
//   clk_i   single clock
//   rst_i   asynchronous active-high reset
//   bus     sampling_decimator_if.slave (data_i/valid_i/clear_i/log2_n_i in,
//           data_o/valid_o/busy_o out)

module sampling_decimator #(
    parameter int WIDTH    = 16,
    parameter int MAX_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    sampling_decimator_if.slave   bus
);
    localparam int            KW    = $clog2(MAX_LOG2 + 1);
    localparam int            AW    = WIDTH + MAX_LOG2;
    localparam logic [KW-1:0] K_MAX = KW'(MAX_LOG2);

    // Registered state
    logic signed [AW-1:0]    acc_q;
    logic [MAX_LOG2-1:0]     cnt_q;
    logic [KW-1:0]           k_act_q;
    logic signed [WIDTH-1:0] data_q;
    logic                    valid_q;
    logic                    busy_q;

    // Next-state values
    logic signed [AW-1:0]    acc_d;
    logic [MAX_LOG2-1:0]     cnt_d;
    logic [KW-1:0]           k_act_d;
    logic signed [WIDTH-1:0] data_d;
    logic                    valid_d;
    logic                    busy_d;

    // Datapath helpers
    logic [KW-1:0]           k_req;
    logic [KW-1:0]           k_eff;
    logic                    blk_start;
    logic                    blk_last;
    logic [MAX_LOG2:0]       last_idx;
    logic signed [AW-1:0]    sample_ext;
    logic signed [AW-1:0]    sum;
    logic signed [AW:0]      round_term;
    logic signed [AW:0]      rounded;

    // Block bookkeeping and rounding arithmetic.
    always_comb begin
        k_req     = (bus.log2_n_i > K_MAX) ? K_MAX : bus.log2_n_i;
        blk_start = (cnt_q == '0);
        // A sample that both starts and ends a block must use the freshly
        // requested k, not the stale k_act from the previous block.
        k_eff     = blk_start ? k_req : k_act_q;

        // Index of the final sample of the block: 2^k - 1. One extra bit so
        // k = MAX_LOG2 does not wrap.
        last_idx  = ((MAX_LOG2 + 1)'(1) << k_eff) - (MAX_LOG2 + 1)'(1);
        blk_last  = ({1'b0, cnt_q} == last_idx);

        sample_ext = {{MAX_LOG2{bus.data_i[WIDTH-1]}}, bus.data_i};
        sum        = blk_start ? sample_ext : (acc_q + sample_ext);

        // Half-LSB bias for round-half-up; k = 0 is a plain passthrough.
        // One guard bit keeps sum + bias from overflowing at full scale.
        round_term = (k_eff == '0) ? '0 : ((AW + 1)'(1) << (k_eff - KW'(1)));
        rounded    = {sum[AW-1], sum} + round_term;
    end

    // Next-state logic.
    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        k_act_d = k_act_q;
        data_d  = data_q;
        valid_d = 1'b0;

        if (bus.clear_i) begin
            // Abort wins over a coincident sample; data_o keeps its value.
            acc_d = '0;
            cnt_d = '0;
        end else if (bus.valid_i) begin
            if (blk_start) begin
                k_act_d = k_req;
            end
            if (blk_last) begin
                acc_d   = '0;
                cnt_d   = '0;
                valid_d = 1'b1;
                // The average of WIDTH-bit samples always fits WIDTH bits.
                data_d  = WIDTH'(rounded >>> k_eff);
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + MAX_LOG2'(1);
            end
        end

        busy_d = (cnt_d != '0);
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            k_act_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            k_act_q <= k_act_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.data_o  = data_q;
    assign bus.valid_o = valid_q;
    assign bus.busy_o  = busy_q;

endmodule

// File: tb/tb_sampling_decimator.sv
// tb/tb_sampling_decimator.sv - self-checking bench for sampling_decimator

module tb_sampling_decimator;
    localparam int WIDTH    = 16;
    localparam int MAX_LOG2 = 10;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    sampling_decimator_if #(.WIDTH(WIDTH), .MAX_LOG2(MAX_LOG2)) bus ();

    sampling_decimator #(.WIDTH(WIDTH), .MAX_LOG2(MAX_LOG2)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference model: list of samples in the open block plus its latched k.
    longint blk_q[$];
    int     m_k       = 0;
    longint exp_data  = 0;
    bit     exp_valid = 0;
    bit     exp_busy  = 0;
    int     strobes   = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint block_avg(input longint s, input int k);
        longint d, n, q;
        d = longint'(1) << k;
        n = s + ((k > 0) ? d / 2 : 0);
        q = n / d;
        if ((n % d) != 0 && n < 0) q = q - 1;
        return q;
    endfunction

    task automatic model_reset();
        blk_q.delete();
        m_k       = 0;
        exp_data  = 0;
        exp_valid = 0;
        exp_busy  = 0;
    endtask

    // One clock: drive inputs, advance the model, check after the edge.
    task automatic cycle(input bit v, input logic signed [15:0] d, input bit clr, input int kreq);
        longint s;
        bus.valid_i  = v;
        bus.data_i   = d;
        bus.clear_i  = clr;
        bus.log2_n_i = 4'(kreq);

        exp_valid = 0;
        if (clr) begin
            blk_q.delete();
        end else if (v) begin
            if (blk_q.size() == 0) m_k = (kreq > MAX_LOG2) ? MAX_LOG2 : kreq;
            blk_q.push_back(longint'(d));
            if (blk_q.size() == (1 << m_k)) begin
                s = 0;
                foreach (blk_q[i]) s += blk_q[i];
                exp_data  = block_avg(s, m_k);
                exp_valid = 1;
                blk_q.delete();
            end
        end
        exp_busy = (blk_q.size() != 0);

        @(posedge clk_i);
        #1;
        if (bus.valid_o === 1'b1) strobes++;
        chk("valid_o", longint'(bus.valid_o), longint'(exp_valid));
        chk("data_o", longint'($signed(bus.data_o)), exp_data);
        chk("busy_o", longint'(bus.busy_o), longint'(exp_busy));
    endtask

    initial begin
        int s0;
        bus.valid_i  = 0;
        bus.data_i   = '0;
        bus.clear_i  = 0;
        bus.log2_n_i = '0;
        model_reset();

        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_data_o", longint'($signed(bus.data_o)), 0);
        chk("rst_valid_o", longint'(bus.valid_o), 0);
        chk("rst_busy_o", longint'(bus.busy_o), 0);
        rst_i = 0;

        // k=2: 1,2,3,4
        cycle(1, 16'sd1, 0, 2);
        chk("k2_busy_after_s1", longint'(bus.busy_o), 1);
        cycle(1, 16'sd2, 0, 2);
        cycle(1, 16'sd3, 0, 2);
        chk("k2_no_strobe_early", longint'(bus.valid_o), 0);
        cycle(1, 16'sd4, 0, 2);
        chk("k2_avg", longint'($signed(bus.data_o)), 3);
        chk("k2_strobe", longint'(bus.valid_o), 1);
        chk("k2_busy_after_s4", longint'(bus.busy_o), 0);
        cycle(0, 16'sd0, 0, 2);
        chk("k2_strobe_one_cycle", longint'(bus.valid_o), 0);

        // k=1 signed rounding and full-scale
        cycle(1, -16'sd3, 0, 1);
        cycle(1, -16'sd2, 0, 1);
        chk("k1_neg_round", longint'($signed(bus.data_o)), -2);
        cycle(1, 16'sd32767, 0, 1);
        cycle(1, 16'sd32767, 0, 1);
        chk("k1_pos_full", longint'($signed(bus.data_o)), 32767);
        cycle(1, -16'sd32768, 0, 1);
        cycle(1, -16'sd32768, 0, 1);
        chk("k1_neg_full", longint'($signed(bus.data_o)), -32768);

        // k=0 passthrough, valid_o held high
        cycle(1, 16'sd5, 0, 0);
        chk("k0_a", longint'($signed(bus.data_o)), 5);
        cycle(1, -16'sd7, 0, 0);
        chk("k0_b", longint'($signed(bus.data_o)), -7);
        chk("k0_b_valid", longint'(bus.valid_o), 1);
        cycle(1, 16'sd100, 0, 0);
        chk("k0_c", longint'($signed(bus.data_o)), 100);
        cycle(0, 16'sd0, 0, 0);

        // Gapped input at k=3
        strobes = 0;
        for (int i = 0; i < 16; i++) cycle(((i % 2) == 0), 16'sd10, 0, 3);
        chk("gap_strobe_count", strobes, 1);
        chk("gap_avg", longint'($signed(bus.data_o)), 10);

        // k changed mid-block from 2 to 1
        strobes = 0;
        cycle(1, 16'sd8, 0, 2);
        cycle(1, 16'sd8, 0, 2);
        cycle(1, 16'sd0, 0, 1);
        chk("kchg_no_early", strobes, 0);
        cycle(1, 16'sd0, 0, 1);
        chk("kchg_close4", longint'(bus.valid_o), 1);
        chk("kchg_avg4", longint'($signed(bus.data_o)), 4);
        cycle(1, 16'sd6, 0, 1);
        cycle(1, 16'sd7, 0, 1);
        chk("kchg_close2", longint'(bus.valid_o), 1);
        chk("kchg_avg2", longint'($signed(bus.data_o)), 7);

        // log2_n_i=15 clamps to 1024-sample blocks
        strobes = 0;
        for (int i = 0; i < 1024; i++) cycle(1, 16'($urandom), 0, 15);
        chk("clamp_strobe_count", strobes, 1);
        chk("clamp_strobe_last", longint'(bus.valid_o), 1);

        // clear_i together with third sample of a k=2 block
        strobes = 0;
        cycle(1, 16'sd100, 0, 2);
        cycle(1, 16'sd100, 0, 2);
        cycle(1, 16'sd100, 1, 2);
        chk("clr_busy", longint'(bus.busy_o), 0);
        for (int i = 0; i < 4; i++) cycle(1, 16'sd4, 0, 2);
        chk("clr_strobe_count", strobes, 1);
        chk("clr_avg", longint'($signed(bus.data_o)), 4);

        // Asynchronous reset mid-block
        cycle(1, 16'sd50, 0, 2);
        cycle(1, 16'sd50, 0, 2);
        bus.valid_i = 0;
        #2 rst_i = 1;
        #1;
        chk("arst_data_o", longint'($signed(bus.data_o)), 0);
        chk("arst_valid_o", longint'(bus.valid_o), 0);
        chk("arst_busy_o", longint'(bus.busy_o), 0);
        model_reset();
        @(posedge clk_i);
        #1 rst_i = 0;
        for (int i = 0; i < 3; i++) cycle(1, 16'sd9, 0, 2);
        chk("arst_no_stale_strobe", longint'(bus.valid_o), 0);
        cycle(1, 16'sd9, 0, 2);
        chk("arst_fresh_avg", longint'($signed(bus.data_o)), 9);

        // Randomized stream against the model
        for (int i = 0; i < 3000; i++) begin
            s0 = $urandom_range(0, 99);
            cycle(($urandom_range(0, 3) != 0), 16'($urandom), (s0 == 0),
                  (s0 == 1) ? 12 : int'($urandom_range(0, 5)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
